// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display value input and multiplexed seven-segment outputs
interface seg7_scan_driver_if;
  logic [7:0] in_data;
  logic [6:0] seg_n;
  logic [1:0] digit_n;
  logic       frame_tick;

  modport master (
    output in_data,
    input  seg_n,
    input  digit_n,
    input  frame_tick
  );

  modport slave (
    input  in_data,
    output seg_n,
    output digit_n,
    output frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - two-digit multiplexed seven-segment scanner with blanking
// Optional leading-zero suppression on digit 1 via macro SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic               clk,
  input  logic               reset_n,
  seg7_scan_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    DIG0   = 2'd1,
    BLANK1 = 2'd2,
    DIG1   = 2'd3
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
  localparam logic [6:0]  SEG_OFF    = 7'h7F;
  localparam logic [1:0]  DIGIT_OFF  = 2'b11;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_frame;
  logic [6:0]  r_seg_n;
  logic [1:0]  r_digit_n;
  logic        r_frame_tick;

  logic        w_blank_phase;
  logic        w_last;
  state_t      w_next_state;
  logic [7:0]  w_next_frame;
  logic [6:0]  w_seg_n;
  logic [1:0]  w_digit_n;
  logic        w_frame_tick;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_blank_phase = (r_state == BLANK0) || (r_state == BLANK1);
  assign w_last        = (r_cnt == (w_blank_phase ? BLANK_LAST : DIV_LAST));

  // Next state and frame are resolved combinationally so the output registers
  // can be loaded from them, keeping outputs aligned with the state register.
  always_comb begin
    w_next_state = r_state;
    w_next_frame = r_frame;
    if (w_last) begin
      case (r_state)
        BLANK0: begin
          w_next_state = DIG0;
          w_next_frame = bus.in_data;
        end
        DIG0:    w_next_state = BLANK1;
        BLANK1:  w_next_state = DIG1;
        default: w_next_state = BLANK0;
      endcase
    end
  end

  always_comb begin
    w_seg_n   = SEG_OFF;
    w_digit_n = DIGIT_OFF;
    case (w_next_state)
      DIG0: begin
        w_seg_n   = decode(w_next_frame[3:0]);
        w_digit_n = 2'b10;
      end
      DIG1: begin
`ifdef SEG7_LZ_BLANK_EN
        if (w_next_frame[7:4] != 4'h0) begin
          w_seg_n   = decode(w_next_frame[7:4]);
          w_digit_n = 2'b01;
        end
`else
        w_seg_n   = decode(w_next_frame[7:4]);
        w_digit_n = 2'b01;
`endif
      end
      default: begin
        w_seg_n   = SEG_OFF;
        w_digit_n = DIGIT_OFF;
      end
    endcase
  end

  // Only DIG1 -> BLANK0 raises the tick, so the post-reset BLANK0 never does.
  assign w_frame_tick = w_last && (r_state == DIG1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= BLANK0;
      r_cnt        <= 16'd0;
      r_frame      <= 8'h00;
      r_seg_n      <= SEG_OFF;
      r_digit_n    <= DIGIT_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_last ? 16'd0 : r_cnt + 16'd1;
      r_frame      <= w_next_frame;
      r_seg_n      <= w_seg_n;
      r_digit_n    <= w_digit_n;
      r_frame_tick <= w_frame_tick;
    end
  end

  assign bus.seg_n      = r_seg_n;
  assign bus.digit_n    = r_digit_n;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (DIV=4, BLANK=2)
module tb_seg7_scan_driver;

  localparam int DIV    = 4;
  localparam int BLANK  = 2;
  localparam int PERIOD = 2 * (DIV + BLANK);

  logic clk;
  logic reset_n;
  logic [7:0] in_data;

  seg7_scan_driver_if bus ();
  assign bus.in_data = in_data;

  seg7_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int n_edges;
  logic [7:0] m_frame;
  logic [1:0] prev_digit;
  logic [6:0] seg_tab [16];

  typedef struct {
    logic [7:0] din;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic [1:0] dig1;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the position within the 12-cycle scan since reset release.
  task automatic check_model();
    int q;
    logic [6:0] e_seg;
    logic [1:0] e_dig;
    logic       e_tick;
    q      = n_edges % PERIOD;
    e_seg  = 7'h7F;
    e_dig  = 2'b11;
    e_tick = (q == 0) && (n_edges > 0);
    if (q >= BLANK && q < BLANK + DIV) begin
      e_seg = seg_tab[m_frame[3:0]];
      e_dig = 2'b10;
    end else if (q >= 2 * BLANK + DIV) begin
`ifdef SEG7_LZ_BLANK_EN
      if (m_frame[7:4] != 4'h0) begin
        e_seg = seg_tab[m_frame[7:4]];
        e_dig = 2'b01;
      end
`else
      e_seg = seg_tab[m_frame[7:4]];
      e_dig = 2'b01;
`endif
    end
    chk("seg_n", 32'(bus.seg_n), 32'(e_seg));
    chk("digit_n", 32'(bus.digit_n), 32'(e_dig));
    chk("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
    chk("digit_not_both", 32'(bus.digit_n != 2'b00), 32'd1);
    chk("no_direct_switch",
        32'(!((prev_digit == 2'b10 && bus.digit_n == 2'b01) ||
              (prev_digit == 2'b01 && bus.digit_n == 2'b10))), 32'd1);
    prev_digit = bus.digit_n;
  endtask

  task automatic step();
    @(posedge clk);
    n_edges++;
    if (n_edges % PERIOD == BLANK) m_frame = in_data;
    #1;
    check_model();
  endtask

  task automatic run_to(input int t);
    int k;
    k = 0;
    while ((n_edges % PERIOD) != t && k < 2 * PERIOD) begin
      step();
      k++;
    end
    chk("run_to_reached", 32'(n_edges % PERIOD), 32'(t));
  endtask

  initial begin
    logic [6:0] lz_seg;
    logic [1:0] lz_dig;
    n_cmp = 0;
    n_bad = 0;
    n_edges = 0;
    m_frame = 8'h00;
    prev_digit = 2'b11;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG7_LZ_BLANK_EN
    lz_seg = 7'h7F; lz_dig = 2'b11;
`else
    lz_seg = 7'h40; lz_dig = 2'b01;
`endif
    vecs[0] = '{8'h3A, 7'h08, 7'h30, 2'b01};
    vecs[1] = '{8'h5C, 7'h46, 7'h12, 2'b01};
    vecs[2] = '{8'h05, 7'h12, lz_seg, lz_dig};
    vecs[3] = '{8'h00, 7'h40, lz_seg, lz_dig};
    vecs[4] = '{8'hF0, 7'h40, 7'h0E, 2'b01};
    vecs[5] = '{8'h81, 7'h79, 7'h00, 2'b01};
    vecs[6] = '{8'h9E, 7'h06, 7'h10, 2'b01};
    vecs[7] = '{8'h27, 7'h78, 7'h24, 2'b01};
    vecs[8] = '{8'hD4, 7'h19, 7'h21, 2'b01};
    vecs[9] = '{8'h6B, 7'h03, 7'h02, 2'b01};

    // Reset held across clock edges
    reset_n = 1'b0;
    in_data = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_seg_n", 32'(bus.seg_n), 32'h7F);
    chk("reset_digit_n", 32'(bus.digit_n), 32'h3);
    chk("reset_frame_tick", 32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    n_edges = 0;
    m_frame = 8'h00;

    // Table vectors: capture at q=BLANK, check mid-DIG0 and mid-DIG1
    for (int i = 0; i < 10; i++) begin
      run_to(BLANK - 1);
      in_data = vecs[i].din;
      run_to(BLANK + 1);
      chk($sformatf("vec%0d_dig0_seg", i), 32'(bus.seg_n), 32'(vecs[i].seg0));
      chk($sformatf("vec%0d_dig0_digit", i), 32'(bus.digit_n), 32'h2);
      in_data = ~vecs[i].din;
      run_to(2 * BLANK + DIV + 1);
      chk($sformatf("vec%0d_dig1_seg", i), 32'(bus.seg_n), 32'(vecs[i].seg1));
      chk($sformatf("vec%0d_dig1_digit", i), 32'(bus.digit_n), 32'(vecs[i].dig1));
      run_to(0);
      chk($sformatf("vec%0d_tick", i), 32'(bus.frame_tick), 32'h1);
      step();
      chk($sformatf("vec%0d_tick_clear", i), 32'(bus.frame_tick), 32'h0);
    end

    // No tearing: change input during DIG0
    run_to(BLANK - 1);
    in_data = 8'h3A;
    run_to(BLANK);
    in_data = 8'h5C;
    run_to(2 * BLANK + DIV);
    chk("tear_dig1_old", 32'(bus.seg_n), 32'h30);
    run_to(BLANK);
    chk("tear_next_dig0", 32'(bus.seg_n), 32'h46);
    run_to(2 * BLANK + DIV);
    chk("tear_next_dig1", 32'(bus.seg_n), 32'h12);

    // Random input activity against the model
    for (int i = 0; i < 400; i++) begin
      in_data = 8'($urandom);
      step();
    end

    // Full sweep of every display value
    for (int v = 0; v < 256; v++) begin
      run_to(BLANK - 1);
      in_data = 8'(v);
      run_to(PERIOD - 1);
    end

    // Reset pulse mid-DIG1 blanks asynchronously
    in_data = 8'h5C;
    run_to(2 * BLANK + DIV + 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_seg_n", 32'(bus.seg_n), 32'h7F);
    chk("async_digit_n", 32'(bus.digit_n), 32'h3);
    chk("async_frame_tick", 32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    @(negedge clk);
    in_data = 8'hE9;
    reset_n = 1'b1;
    n_edges = 0;
    m_frame = 8'h00;
    prev_digit = 2'b11;
    run_to(BLANK);
    chk("post_reset_frame_dig0", 32'(bus.seg_n), 32'h10);
    run_to(2 * BLANK + DIV);
    chk("post_reset_frame_dig1", 32'(bus.seg_n), 32'h06);
    for (int i = 0; i < 100; i++) begin
      in_data = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
